icache_ctrl: RTL and testbench

Instruction-cache controller that sequences the 128-set direct-mapped tag RAM (21-bit entries {valid, tag[19:0]}, index addr[11:5], 1-cycle read latency) and the matching line-data RAM. It performs the post-reset invalidation sweep, hit/miss lookup, 8-beat line refill from the memory side, and single-set invalidation. It sits between the fetch stage and the bus interface; the tag and data RAMs are instantiated beside it, not inside it.

---
 rtl/icache_pkg.sv | 42 ++++
 rtl/icache_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types, constants and address-field helpers for the instruction-cache controller.
package icache_pkg;

    localparam int TAG_W   = 20;
    localparam int INDEX_W = 7;
    localparam int WORDS   = 8;
    localparam int OFFS_W  = 3;
    localparam int SETS    = 1 << INDEX_W;
    localparam int ENTRY_W = TAG_W + 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_REPLAY,
        S_INV
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [OFFS_W-1:0]  offset;
        logic [1:0]         byte_sel;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [31:0] addr);
        return addr_fields_t'(addr);
    endfunction

    function automatic logic [31:0] line_base(input logic [TAG_W-1:0] tag,
                                              input logic [INDEX_W-1:0] index);
        return {tag, index, 5'b0};
    endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction-cache sequencer for external tag/data RAMs: reset sweep,
// lookup, 8-beat line refill and single-set invalidation.
//
//   state  | meaning
//   INIT   | post-reset sweep, clears one tag entry per cycle
//   IDLE   | accept an invalidate (wins) or a fetch
//   LOOKUP | RAM read returned; a hit delivers data and may take the next fetch
//   MISS   | line request held until memory acknowledges
//   REFILL | write returning beats; the last beat also writes the tag
//   REPLAY | re-read the freshly filled set
//   INV    | clear the tag of the registered set
module icache_ctrl
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,

    input  logic               cpu_req,
    input  logic [31:0]        cpu_addr,
    output logic               cpu_addr_ok,
    output logic               cpu_data_ok,

    input  logic               inv_req,
    input  logic [INDEX_W-1:0] inv_index,
    output logic               inv_ack,

    output logic               tag_en,
    output logic [3:0]         tag_wen,
    output logic [INDEX_W-1:0] tag_index,
    output logic [ENTRY_W-1:0] tag_wdata,
    input  logic [ENTRY_W-1:0] tag_rdata,

    output logic               data_en,
    output logic [WORDS-1:0]   data_wen,
    output logic [INDEX_W-1:0] data_index,
    output logic [31:0]        data_wdata,

    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic               mem_rvalid,
    input  logic               mem_rlast,
    input  logic [31:0]        mem_rdata
);

    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;
    addr_fields_t       addr_q, addr_d;
    logic [INDEX_W-1:0] inv_q, inv_d;

    addr_fields_t req;
    tag_entry_t   rd_entry;
    tag_entry_t   fill_entry;
    logic         hit;
    logic         unused_addr_bits;

    assign req        = split_addr(cpu_addr);
    assign rd_entry   = tag_entry_t'(tag_rdata);
    assign hit        = rd_entry.valid && (rd_entry.tag == addr_q.tag);
    assign fill_entry = '{valid: 1'b1, tag: addr_q.tag};

    // Word offset and byte lanes only matter to the fetch stage reading the data RAM.
    assign unused_addr_bits = ^{addr_q.offset, addr_q.byte_sel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            addr_q  <= '0;
            inv_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inv_q   <= inv_d;
        end
    end

    // Outputs are held low while rst is high so a reset mid-burst silences the RAMs at once.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        inv_d       = inv_q;
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        inv_ack     = 1'b0;
        tag_en      = 1'b0;
        tag_wen     = 4'h0;
        tag_index   = '0;
        tag_wdata   = '0;
        data_en     = 1'b0;
        data_wen    = '0;
        data_index  = '0;
        data_wdata  = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;

        if (!rst) begin
            case (state_q)
                S_INIT: begin
                    tag_en    = 1'b1;
                    tag_wen   = 4'hF;
                    tag_index = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_SET) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (inv_req) begin
                        inv_ack = 1'b1;
                        inv_d   = inv_index;
                        state_d = S_INV;
                    end else begin
                        cpu_addr_ok = 1'b1;
                        if (cpu_req) begin
                            addr_d     = req;
                            tag_en     = 1'b1;
                            data_en    = 1'b1;
                            tag_index  = req.index;
                            data_index = req.index;
                            state_d    = S_LOOKUP;
                        end
                    end
                end

                S_LOOKUP: begin
                    if (hit) begin
                        cpu_data_ok = 1'b1;
                        if (inv_req) begin
                            // Drop back to IDLE so the pending invalidate gets its slot.
                            state_d = S_IDLE;
                        end else begin
                            cpu_addr_ok = 1'b1;
                            if (cpu_req) begin
                                addr_d     = req;
                                tag_en     = 1'b1;
                                data_en    = 1'b1;
                                tag_index  = req.index;
                                data_index = req.index;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        state_d = S_MISS;
                    end
                end

                S_MISS: begin
                    mem_req  = 1'b1;
                    mem_addr = line_base(addr_q.tag, addr_q.index);
                    if (mem_ack) begin
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end

                S_REFILL: begin
                    if (mem_rvalid) begin
                        data_en    = 1'b1;
                        data_wen   = WORDS'(1) << cnt_q[OFFS_W-1:0];
                        data_index = addr_q.index;
                        data_wdata = mem_rdata;
                        cnt_d      = cnt_q + 1'b1;
                        if (mem_rlast) begin
                            // A short burst still ends the refill; the counter simply restarts.
                            tag_en    = 1'b1;
                            tag_wen   = 4'hF;
                            tag_index = addr_q.index;
                            tag_wdata = fill_entry;
                            cnt_d     = '0;
                            state_d   = S_REPLAY;
                        end
                    end
                end

                S_REPLAY: begin
                    tag_en     = 1'b1;
                    data_en    = 1'b1;
                    tag_index  = addr_q.index;
                    data_index = addr_q.index;
                    state_d    = S_LOOKUP;
                end

                S_INV: begin
                    tag_en    = 1'b1;
                    tag_wen   = 4'hF;
                    tag_index = inv_q;
                    state_d   = S_IDLE;
                end

                default: begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with behavioural tag/data RAMs and a scripted memory side.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_addr_ok, cpu_data_ok;
    logic        inv_req = 1'b0;
    logic [6:0]  inv_index = '0;
    logic        inv_ack;
    logic        tag_en;
    logic [3:0]  tag_wen;
    logic [6:0]  tag_index;
    logic [20:0] tag_wdata;
    logic [20:0] tag_rdata;
    logic        data_en;
    logic [7:0]  data_wen;
    logic [6:0]  data_index;
    logic [31:0] data_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic        mem_rlast = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    icache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_addr_ok (cpu_addr_ok),
        .cpu_data_ok (cpu_data_ok),
        .inv_req     (inv_req),
        .inv_index   (inv_index),
        .inv_ack     (inv_ack),
        .tag_en      (tag_en),
        .tag_wen     (tag_wen),
        .tag_index   (tag_index),
        .tag_wdata   (tag_wdata),
        .tag_rdata   (tag_rdata),
        .data_en     (data_en),
        .data_wen    (data_wen),
        .data_index  (data_index),
        .data_wdata  (data_wdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rlast   (mem_rlast),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAMs with 1-cycle read latency, as placed beside the controller.
    logic [20:0] tag_mem [0:127];
    logic [31:0] data_mem [0:127][0:7];
    logic [31:0] data_line [0:7];

    always @(posedge clk) begin
        if (tag_en) begin
            if (tag_wen != 4'h0) tag_mem[tag_index] <= tag_wdata;
            else                 tag_rdata <= tag_mem[tag_index];
        end
        if (data_en) begin
            if (data_wen != 8'h00) begin
                for (int w = 0; w < 8; w++) begin
                    if (data_wen[w]) data_mem[data_index][w] <= data_wdata;
                end
            end else begin
                for (int w = 0; w < 8; w++) data_line[w] <= data_mem[data_index][w];
            end
        end
    end

    function automatic logic [31:0] pat(input logic [31:0] addr, input int k);
        logic [2:0] w;
        w = 3'(k);
        return {addr[31:5], w, 2'b00} ^ 32'h5A5A_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at the first INIT cycle; leaves one cycle into IDLE.
    task automatic check_sweep(input string name);
        int bad_cycle;
        logic [6:0] bad_idx;
        bad_cycle = -1;
        bad_idx   = '0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (bad_cycle < 0 && (tag_en !== 1'b1 || tag_wen !== 4'hF || tag_wdata !== 21'h0 ||
                                  tag_index !== 7'(i) || cpu_addr_ok !== 1'b0)) begin
                bad_cycle = i;
                bad_idx   = tag_index;
            end
            tick();
        end
        checks++;
        if (bad_cycle >= 0) begin
            errors++;
            $display("FAIL %s_sweep: cycle %0d got tag_index=%0d, required index=%0d wdata=0 wen=F", name, bad_cycle, bad_idx, bad_cycle);
        end
        @(negedge clk);
        checks++;
        if (cpu_addr_ok !== 1'b1 || tag_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_129: got cpu_addr_ok=%b tag_en=%b, required 1/0", name, cpu_addr_ok, tag_en);
        end
        tick();
    endtask

    // Entered in IDLE; fetch must miss, refill, and end mid-cycle in the LOOKUP hit.
    task automatic do_miss(input logic [31:0] addr, input int ack_wait, input bit gap, input bit inv_during);
        logic [6:0]  idx;
        logic [31:0] line;
        logic [2:0]  off;
        logic [7:0]  wexp;
        bit          ok;
        idx  = addr[11:5];
        line = {addr[31:5], 5'b0};
        off  = addr[4:2];
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(negedge clk);
        checks++;
        if (cpu_addr_ok !== 1'b1 || tag_en !== 1'b1 || tag_index !== idx) begin
            errors++;
            $display("FAIL miss_accept %h: got addr_ok=%b tag_en=%b idx=%0d, required 1/1/%0d", addr, cpu_addr_ok, tag_en, tag_index, idx);
        end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_data_ok !== 1'b0 || cpu_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL miss_lookup %h: got data_ok=%b addr_ok=%b, required 0/0", addr, cpu_data_ok, cpu_addr_ok);
        end
        ok = 1'b1;
        for (int c = 0; c <= ack_wait; c++) begin
            tick();
            mem_ack = (c == ack_wait);
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_addr !== line) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL miss_mem_req %h: got mem_req=%b mem_addr=%h, required 1/%h", addr, mem_req, mem_addr, line);
        end
        tick();
        mem_ack = 1'b0;
        if (inv_during) begin
            inv_req   = 1'b1;
            inv_index = idx;
        end
        for (int k = 0; k < 8; k++) begin
            if (gap && k == 3) begin
                mem_rvalid = 1'b0;
                @(negedge clk);
                checks++;
                if (data_en !== 1'b0 || tag_en !== 1'b0) begin
                    errors++;
                    $display("FAIL refill_gap: got data_en=%b tag_en=%b, required 0/0", data_en, tag_en);
                end
                tick();
            end
            wexp       = 8'b1 << k;
            mem_rvalid = 1'b1;
            mem_rdata  = pat(addr, k);
            mem_rlast  = (k == 7);
            @(negedge clk);
            checks++;
            if (data_en !== 1'b1 || data_wen !== wexp || data_index !== idx || data_wdata !== pat(addr, k) ||
                inv_ack !== 1'b0 || tag_en !== (k == 7)) begin
                errors++;
                $display("FAIL refill_beat%0d: got wen=%h idx=%0d wdata=%h tag_en=%b inv_ack=%b, required %h/%0d/%h/%b/0",
                         k, data_wen, data_index, data_wdata, tag_en, inv_ack, wexp, idx, pat(addr, k), (k == 7));
            end
            if (k == 7) begin
                checks++;
                if (tag_wen !== 4'hF || tag_wdata !== {1'b1, addr[31:12]} || tag_index !== idx) begin
                    errors++;
                    $display("FAIL refill_tag_write: got wen=%h wdata=%h idx=%0d, required F/%h/%0d", tag_wen, tag_wdata, tag_index, {1'b1, addr[31:12]}, idx);
                end
            end
            tick();
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        @(negedge clk);
        checks++;
        if (tag_en !== 1'b1 || tag_wen !== 4'h0 || data_en !== 1'b1 || data_wen !== 8'h00 ||
            tag_index !== idx || cpu_data_ok !== 1'b0 || inv_ack !== 1'b0) begin
            errors++;
            $display("FAIL replay: got tag_en=%b tag_wen=%h data_en=%b idx=%0d data_ok=%b inv_ack=%b, required 1/0/1/%0d/0/0",
                     tag_en, tag_wen, data_en, tag_index, cpu_data_ok, inv_ack, idx);
        end
        tick();
        @(negedge clk);
        checks++;
        if (cpu_data_ok !== 1'b1 || data_line[off] !== pat(addr, off) || cpu_addr_ok !== !inv_during ||
            inv_ack !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL miss_hit %h: got data_ok=%b word=%h addr_ok=%b inv_ack=%b, required 1/%h/%b/0",
                     addr, cpu_data_ok, data_line[off], cpu_addr_ok, inv_ack, pat(addr, off), !inv_during);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_addr_ok, cpu_data_ok, inv_ack, tag_en, data_en, mem_req} !== 6'b0 ||
            tag_wen !== 4'h0 || data_wen !== 8'h00 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ok=%b%b inv_ack=%b tag_en=%b data_en=%b mem_req=%b, required all 0",
                     cpu_addr_ok, cpu_data_ok, inv_ack, tag_en, data_en, mem_req);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_sweep("reset");
    endtask

    task automatic test_cold_miss();
        do_miss(32'h0000_1040, 2, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_1040;
        @(negedge clk);
        checks++;
        if (cpu_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got addr_ok=%b, required 1", cpu_addr_ok);
        end
        tick();
        cpu_addr = 32'h0000_1044;
        @(negedge clk);
        checks++;
        if (cpu_data_ok !== 1'b1 || cpu_addr_ok !== 1'b1 || data_line[0] !== pat(32'h0000_1040, 0) ||
            mem_req !== 1'b0 || tag_en !== 1'b1 || tag_index !== 7'd2) begin
            errors++;
            $display("FAIL b2b_first: got data_ok=%b addr_ok=%b word=%h mem_req=%b, required 1/1/%h/0",
                     cpu_data_ok, cpu_addr_ok, data_line[0], mem_req, pat(32'h0000_1040, 0));
        end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_data_ok !== 1'b1 || data_line[1] !== pat(32'h0000_1044, 1) || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got data_ok=%b word=%h mem_req=%b, required 1/%h/0",
                     cpu_data_ok, data_line[1], mem_req, pat(32'h0000_1044, 1));
        end
        tick();
        @(negedge clk);
        checks++;
        if (cpu_data_ok !== 1'b0 || cpu_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got data_ok=%b addr_ok=%b, required 0/1", cpu_data_ok, cpu_addr_ok);
        end
        tick();
    endtask

    task automatic test_replace();
        do_miss(32'h0000_2040, 0, 1'b1, 1'b0);
        tick();
        do_miss(32'h0000_1040, 1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_invalidate();
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_2040;
        inv_req   = 1'b1;
        inv_index = 7'd5;
        @(negedge clk);
        checks++;
        if (inv_ack !== 1'b1 || cpu_addr_ok !== 1'b0 || tag_en !== 1'b0) begin
            errors++;
            $display("FAIL inv_priority: got inv_ack=%b addr_ok=%b tag_en=%b, required 1/0/0", inv_ack, cpu_addr_ok, tag_en);
        end
        tick();
        cpu_req = 1'b0;
        inv_req = 1'b0;
        @(negedge clk);
        checks++;
        if (tag_en !== 1'b1 || tag_wen !== 4'hF || tag_wdata !== 21'h0 || tag_index !== 7'd5 || inv_ack !== 1'b0) begin
            errors++;
            $display("FAIL inv_write5: got tag_en=%b wen=%h wdata=%h idx=%0d, required 1/F/0/5", tag_en, tag_wen, tag_wdata, tag_index);
        end
        tick();
        do_miss(32'h0000_2040, 1, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if (inv_ack !== 1'b1 || cpu_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL inv_held_ack: got inv_ack=%b addr_ok=%b, required 1/0", inv_ack, cpu_addr_ok);
        end
        tick();
        inv_req = 1'b0;
        @(negedge clk);
        checks++;
        if (tag_en !== 1'b1 || tag_wen !== 4'hF || tag_wdata !== 21'h0 || tag_index !== 7'd2) begin
            errors++;
            $display("FAIL inv_write2: got tag_en=%b wen=%h wdata=%h idx=%0d, required 1/F/0/2", tag_en, tag_wen, tag_wdata, tag_index);
        end
        tick();
        do_miss(32'h0000_2040, 0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_refill();
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_3064;
        tick();
        cpu_req = 1'b0;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pat(32'h0000_3064, k);
            tick();
        end
        mem_rdata = pat(32'h0000_3064, 4);
        @(negedge clk);
        checks++;
        if (data_wen !== 8'h10 || data_index !== 7'd3) begin
            errors++;
            $display("FAIL midrst_beat4: got wen=%h idx=%0d, required 10/3", data_wen, data_index);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || data_en !== 1'b0 || data_wen !== 8'h00 || tag_en !== 1'b0 || cpu_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got mem_req=%b data_en=%b wen=%h tag_en=%b, required all 0", mem_req, data_en, data_wen, tag_en);
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        check_sweep("midrst");
        do_miss(32'h0000_2040, 0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_replace();
        test_invalidate();
        test_reset_mid_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
